// File: rtl/uart_tx_fifo_pkg.sv
// Shared encodings for the FIFO-fed UART transmitter: parity modes and FSM states.
package uart_tx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port; writes when full and
// reads when empty are ignored.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the current count, so a push is refused even if a pop
  // frees a slot on the same edge.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a small FIFO; frames go out back-to-back with a
// configurable data width, parity mode and stop-bit count.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_valid,
  input  logic [DATA_BITS-1:0]                i_data,
  output logic                                o_ready,
  output logic                                o_uart_tx,
  output logic                                o_busy,
  output logic                                o_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_count
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_q;
  logic                 tx_q;
  logic                 tx_d;
  logic                 baud_tick;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i_valid),
    .pop   (fifo_pop),
    .din   (i_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_fifo_count)
  );

  assign o_ready   = ~fifo_full;
  assign o_uart_tx = tx_q;
  assign baud_tick = (baud_cnt_q == LAST_TICK);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tick && (bit_cnt_q == LAST_DATA))
          state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        if (baud_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more words are queued.
        if (baud_tick && (bit_cnt_q == LAST_STOP)) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    if (fifo_pop)
      shift_d = fifo_dout;
    else if ((state_q == ST_DATA) && baud_tick)
      shift_d = shift_q >> 1;
  end

  // Line level is computed from the next state so the registered pin lines up
  // with the state it belongs to.
  always_comb begin
    o_busy    = (state_q != ST_IDLE);
    o_tx_done = (state_q == ST_STOP) && baud_tick && (bit_cnt_q == LAST_STOP);
    unique case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_q;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      if ((state_d == ST_IDLE) || fifo_pop || baud_tick)
        baud_cnt_q <= '0;
      else
        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
      if ((state_d != state_q) || fifo_pop)
        bit_cnt_q <= '0;
      else if (baud_tick)
        bit_cnt_q <= bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (fifo_pop) parity_q <= calc_parity(fifo_dout);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8N1 instance and a 9-bit odd-parity two-stop
// instance, both checked every cycle against a queue-and-frame-timer model.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int DB_A = 8, PAR_A = 0, SB_A = 1;
  localparam int DB_B = 9, PAR_B = 1, SB_B = 2;

  logic       clk;
  logic       rst_n;
  logic       valid_a, valid_b;
  logic [7:0] data_a;
  logic [8:0] data_b;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] cnt_a, cnt_b;

  int vectors;
  int miscompares;

  logic [8:0] mq [2][DEPTH];
  int         msz [2];
  bit         mact [2];
  int         mt [2];
  logic [8:0] mcur [2];

  uart_tx_fifo #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(DB_A), .PARITY(PAR_A),
    .STOP_BITS(SB_A), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .reset(rst_n), .i_valid(valid_a), .i_data(data_a),
    .o_ready(ready_a), .o_uart_tx(tx_a), .o_busy(busy_a),
    .o_tx_done(done_a), .o_fifo_count(cnt_a)
  );

  uart_tx_fifo #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(DB_B), .PARITY(PAR_B),
    .STOP_BITS(SB_B), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .reset(rst_n), .i_valid(valid_b), .i_data(data_b),
    .o_ready(ready_b), .o_uart_tx(tx_b), .o_busy(busy_b),
    .o_tx_done(done_b), .o_fifo_count(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int flen(input int i);
    int db, par, sb;
    db  = (i == 0) ? DB_A : DB_B;
    par = (i == 0) ? PAR_A : PAR_B;
    sb  = (i == 0) ? SB_A : SB_B;
    return (1 + db + ((par != 0) ? 1 : 0) + sb) * DIV;
  endfunction

  // Line level of bit position p in the frame carrying word w.
  function automatic logic frame_bit(input int i, input logic [8:0] w, input int p);
    int   db, par;
    logic x;
    db  = (i == 0) ? DB_A : DB_B;
    par = (i == 0) ? PAR_A : PAR_B;
    x   = ^w;
    if (par == 1) x = ~x;
    if (p == 0) return 1'b0;
    if (p <= db) return w[p-1];
    if ((par != 0) && (p == db + 1)) return x;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msz[i]  = 0;
      mact[i] = 1'b0;
      mt[i]   = 0;
      mcur[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic       v;
      logic [8:0] d;
      int         pre;
      bit         ending;
      v      = (i == 0) ? valid_a : valid_b;
      d      = (i == 0) ? {1'b0, data_a} : data_b;
      pre    = msz[i];
      ending = mact[i] && (mt[i] == flen(i) - 1);
      if ((!mact[i] || ending) && (msz[i] > 0)) begin
        mcur[i] = mq[i][0];
        for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
        msz[i]--;
        mact[i] = 1'b1;
        mt[i]   = 0;
      end else if (ending) begin
        mact[i] = 1'b0;
      end else if (mact[i]) begin
        mt[i]++;
      end
      if (v && (pre < DEPTH)) begin
        mq[i][msz[i]] = d;
        msz[i]++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic cmp_inst(input int i, input logic tx, input logic busy,
                          input logic done, input logic rdy, input logic [2:0] cnt);
    logic line;
    line = mact[i] ? frame_bit(i, mcur[i], mt[i] / DIV) : 1'b1;
    chk($sformatf("dut%0d.tx", i),    tx,   line);
    chk($sformatf("dut%0d.busy", i),  busy, mact[i]);
    chk($sformatf("dut%0d.done", i),  done, mact[i] && (mt[i] == flen(i) - 1));
    chk($sformatf("dut%0d.ready", i), rdy,  msz[i] < DEPTH);
    chk($sformatf("dut%0d.count", i), cnt,  msz[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        cmp_inst(0, tx_a, busy_a, done_a, ready_a, cnt_a);
        cmp_inst(1, tx_b, busy_b, done_b, ready_b, cnt_b);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (((msz[0] != 0) || mact[0] || (msz[1] != 0) || mact[1]) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [9:0]  lit_a;
    logic [12:0] lit_b;
    int          low_seen;
    int          n;
    int          pa, pb;

    vectors     = 0;
    miscompares = 0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.tx",    tx_a,    1);
    chk("rst.busy",  busy_a,  0);
    chk("rst.done",  done_a,  0);
    chk("rst.count", cnt_a,   0);
    chk("rst.ready", ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 on the 8N1 line and 0x1FF on the 9-bit odd-parity line together.
    lit_a = 10'b1101001010;
    lit_b = 13'b1101111111110;
    valid_a = 1'b1; data_a = 8'hA5;
    valid_b = 1'b1; data_b = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    chk("queued.tx", tx_a, 1);
    chk("queued.count", cnt_a, 1);
    valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 136; c++) begin
      @(negedge clk);
      if ((c % 10) == 5) begin
        if (c / 10 < 10) chk("a5.bit", tx_a, lit_a[c/10]);
        if (c / 10 < 13) chk("b1ff.bit", tx_b, lit_b[c/10]);
      end
      if (c == 99)  chk("a5.done", done_a, 1);
      if (c == 100) chk("a5.busy_after", busy_a, 0);
      if (c == 129) chk("b1ff.done", done_b, 1);
      if (c == 130) chk("b1ff.busy_after", busy_b, 0);
    end
    wait_idle();

    // Six back-to-back writes into an empty depth-4 FIFO: the sixth is refused.
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) chk("full.ready_6th", ready_a, 0);
      valid_a = 1'b1;
      data_a  = 8'(k);
      @(negedge clk);
    end
    valid_a = 1'b0;
    chk("full.count", cnt_a, 4);
    wait_idle();

    // Reset in the middle of data bit 3 with more words still queued.
    for (int k = 0; k < 3; k++) begin
      valid_a = 1'b1; data_a = 8'($urandom);
      valid_b = (k == 0); data_b = 9'($urandom);
      @(negedge clk);
    end
    valid_a = 1'b0; valid_b = 1'b0;
    n = 0;
    while (!(mact[0] && (mt[0] == 44)) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("midreset_wait_timeout", 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.tx_a",    tx_a,   1);
    chk("midrst.busy_a",  busy_a, 0);
    chk("midrst.count_a", cnt_a,  0);
    chk("midrst.tx_b",    tx_b,   1);
    chk("midrst.busy_b",  busy_b, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((tx_a !== 1'b1) || (tx_b !== 1'b1) || busy_a || busy_b) low_seen = 1;
    end
    chk("idle_after_reset", low_seen, 0);

    // Random traffic at varying densities, from sparse to saturating.
    for (int ph = 0; ph < 4; ph++) begin
      pa = (ph == 0) ? 2 : (ph == 1) ? 40 : (ph == 2) ? 0 : 8;
      pb = (ph == 0) ? 1 : (ph == 1) ? 50 : (ph == 2) ? 0 : 6;
      for (int c = 0; c < 1200; c++) begin
        valid_a = ($urandom_range(0, 99) < pa);
        valid_b = ($urandom_range(0, 99) < pb);
        data_a  = 8'($urandom);
        data_b  = 9'($urandom);
        @(negedge clk);
      end
    end
    valid_a = 1'b0; valid_b = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and a ready/valid write interface. It sits between the debug/loader logic and the board TX pin. Queued bytes go out back-to-back with no idle gap between frames. Baud timing is derived internally from the clock, and every line bit lasts exactly `DIV = CLK_FREQ / BAUD_RATE` cycles.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate. `DIV = CLK_FREQ / BAUD_RATE`, integer division, must be ≥ 2.
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: number of entries, power of two, ≥ 2.

Ports, clock and reset first:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_valid` in 1: write request.
- `i_data` in DATA_BITS: word to send.
- `o_ready` out 1: FIFO not full. A write is accepted on an edge where `i_valid & o_ready`.
- `o_uart_tx` out 1: serial line, idle high.
- `o_busy` out 1: FSM not in IDLE.
- `o_tx_done` out 1: one-cycle pulse at the end of each frame.
- `o_fifo_count` out $clog2(FIFO_DEPTH+1): number of entries currently held.

## Operation
- Reset values: `o_uart_tx`=1, `o_busy`=0, `o_tx_done`=0, `o_fifo_count`=0, `o_ready`=1, FSM in IDLE, baud counter at 0.
- Frame order: start bit (0), then data bits LSB first, then parity bit if `PARITY`≠0, then `STOP_BITS` stop bits (1).
- Parity computation: even parity = XOR of the data bits; odd parity = its inverse.
- FSM states:
  - IDLE: if FIFO is non-empty, pop, load the shift register, go to START. Otherwise hold the line high.
  - START → DATA after DIV cycles.
  - DATA shifts one bit every DIV cycles. After DATA_BITS bits, go to PARITY, or to STOP if `PARITY`=0.
  - PARITY → STOP after DIV cycles.
  - STOP lasts STOP_BITS·DIV cycles, then pulses `o_tx_done`. If the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and is cleared whenever a frame starts, so the start bit is never shortened. It is held at 0 while in IDLE.
- FIFO push and pop in the same cycle: count unchanged.
- FIFO full: `o_ready`=0 and the write is ignored, even if a pop occurs in the same cycle.
- FIFO empty: no pop.
- FIFO pointers wrap modulo FIFO_DEPTH.
- `i_data` changes while `o_ready`=0 have no effect.
- Reset asserted mid-frame: the line goes high immediately, the frame is abandoned, and FIFO contents are discarded. No frame starts after reset deassertion without a new write.

## Timing
- Write accepted at edge k with the FSM idle and FIFO empty: FIFO registers the entry at edge k. At edge k+1 the FSM pops it and `o_uart_tx` goes low.
- Start-to-start latency: 1 cycle of FIFO plus 0 cycles of gap.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)·DIV cycles.
- `o_tx_done` is high for exactly one cycle, the last cycle of the final stop bit.
- Consecutive frames: the next start bit begins on the cycle after the last stop-bit cycle.
- `o_uart_tx` is a registered output, glitch-free.

## Structure
- Shared header/package holds `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN` encodings and the FSM state encodings (3 bits).
- The top module contains the FSM, baud counter, shift register and parity logic.
- One sub-module, `sync_fifo`: parameters WIDTH and DEPTH; ports for push, pop, data in/out, full, empty, count. It uses the same `clk` and `reset`.

## Test plan
Common settings for all scenarios: CLK_FREQ=1000, BAUD_RATE=100, so DIV=10.
- **8N1:** write 0xA5 while idle → line low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. `o_tx_done` pulses at cycle 100 after the line falls, and `o_busy` then drops.
- **Parity, DATA_BITS=7:** send 0x55 with even parity → parity bit 0 (four ones in the data). With odd parity → parity bit 1. Frame length is 100 cycles.
- **Full FIFO, FIFO_DEPTH=4:** start idle and drive `i_valid` for 6 consecutive cycles with 0x01..0x06 → first 5 accepted, `o_ready` low on the 6th, 0x06 dropped. Five frames are sent with no gap between stop bit and next start bit, and `o_fifo_count` counts down 4→0.
- **Two stop bits, STOP_BITS=2:** two queued words → stop interval of 20 cycles high, and the second start bit follows immediately.
- **Reset mid-frame:** assert `reset` low during data bit 3 → `o_uart_tx`=1 and `o_busy`=0 asynchronously, `o_fifo_count`=0. After release, the line stays high for 200 cycles with no writes.
- **9-bit data with parity:** DATA_BITS=9, odd parity, data 0x1FF → parity bit 0 (nine ones). Frame is 120 cycles and bit 8 precedes the parity bit.
